vedic_multiplier_4bit: RTL and testbench



---
 rtl/vedic_multiplier_4bit.sv | 93 +++++++++
 tb/tb_vedic_multiplier_4bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vedic_multiplier_4bit.sv
// Unsigned 4x4 -> 8-bit Urdhva-Tiryakbhyam multiplier: four 2x2 Vedic cells feeding an adder tree.
// Optional macro VEDIC_PIPE_EN adds a register stage between the 2x2 cells and the adder tree (latency 2).
module vedic_multiplier_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       in_valid,
  output logic [7:0] out,
  output logic       out_valid
);

  function automatic logic [3:0] vedic_2x2(input logic [1:0] a, input logic [1:0] b);
    logic       c;
    logic [3:0] p;
    p[0] = a[0] & b[0];
    p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    c    = (a[1] & b[0]) & (a[0] & b[1]);
    p[2] = (a[1] & b[1]) ^ c;
    p[3] = (a[1] & b[1]) & c;
    return p;
  endfunction

  // q0 contributes its low half directly; its high half lines up under q3 at weight 4.
  function automatic logic [7:0] vedic_combine(input logic [3:0] p0, input logic [3:0] p1,
                                               input logic [3:0] p2, input logic [3:0] p3);
    logic [4:0] s1;
    logic [5:0] s2;
    s1 = {1'b0, p1} + {1'b0, p2};
    s2 = {1'b0, s1} + {p3, p0[3:2]};
    return {s2, p0[1:0]};
  endfunction

  logic [3:0] q0, q1, q2, q3;
  logic [7:0] out_d, out_q;
  logic       out_valid_d, out_valid_q;

  assign q0 = vedic_2x2(x[1:0], y[1:0]);
  assign q1 = vedic_2x2(x[3:2], y[1:0]);
  assign q2 = vedic_2x2(x[1:0], y[3:2]);
  assign q3 = vedic_2x2(x[3:2], y[3:2]);

`ifdef VEDIC_PIPE_EN
  logic [3:0] q0_d, q1_d, q2_d, q3_d;
  logic [3:0] q0_q, q1_q, q2_q, q3_q;
  logic       pipe_valid_d, pipe_valid_q;

  always_comb begin
    q0_d         = q0;
    q1_d         = q1;
    q2_d         = q2;
    q3_d         = q3;
    pipe_valid_d = in_valid;
    out_d        = vedic_combine(q0_q, q1_q, q2_q, q3_q);
    out_valid_d  = pipe_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0_q         <= 4'h0;
      q1_q         <= 4'h0;
      q2_q         <= 4'h0;
      q3_q         <= 4'h0;
      pipe_valid_q <= 1'b0;
    end else begin
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      q3_q         <= q3_d;
      pipe_valid_q <= pipe_valid_d;
    end
  end
`else
  always_comb begin
    out_d       = vedic_combine(q0, q1, q2, q3);
    out_valid_d = in_valid;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vedic_multiplier_4bit.sv
// Self-checking bench for vedic_multiplier_4bit: directed + exhaustive + random operands
// compared against an arithmetic x*y model delayed through a latency queue.
module tb_vedic_multiplier_4bit;

`ifdef VEDIC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] y;
  logic       in_valid;
  logic [7:0] out;
  logic       out_valid;

  typedef struct packed {
    logic       v;
    logic [7:0] p;
  } exp_t;

  exp_t pending[$];
  int   passed;
  int   total;

  vedic_multiplier_4bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] exp_out, input logic exp_v);
    total++;
    assert (out === exp_out) passed++;
    else $error("[TB] FAIL %s out: observed %0d expected %0d", tag, out, exp_out);
    total++;
    assert (out_valid === exp_v) passed++;
    else $error("[TB] FAIL %s out_valid: observed %0b expected %0b", tag, out_valid, exp_v);
  endtask

  // Everything in flight is lost on reset; the pipelined build then emits zeros first.
  task automatic resetModel();
    exp_t z;
    z.v = 1'b0;
    z.p = 8'h00;
    pending.delete();
    for (int i = 0; i < LAT - 1; i++) pending.push_back(z);
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic v);
    exp_t e;
    exp_t n;
    x        = a;
    y        = b;
    in_valid = v;
    @(posedge clk);
    n.v = v;
    n.p = 8'(int'(a) * int'(b));
    pending.push_back(n);
    e = pending.pop_front();
    #1;
    checkOutput(tag, e.p, e.v);
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    x        = 4'hF;
    y        = 4'hF;
    in_valid = 1'b1;
    resetModel();

    #2;
    checkOutput("reset_async", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < LAT; k++) applyStimulus("reset_release_15x15", 4'hF, 4'hF, 1'b1);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        applyStimulus("sweep", 4'(i), 4'(j), 1'b1);

    applyStimulus("spot_3x5", 4'd3, 4'd5, 1'b1);
    applyStimulus("spot_7x9", 4'd7, 4'd9, 1'b1);
    applyStimulus("spot_12x11", 4'd12, 4'd11, 1'b1);
    applyStimulus("spot_15x15", 4'd15, 4'd15, 1'b1);
    applyStimulus("zero_0x13", 4'd0, 4'd13, 1'b1);
    applyStimulus("ident_1x13", 4'd1, 4'd13, 1'b1);
    applyStimulus("ident_13x1", 4'd13, 4'd1, 1'b1);

    applyStimulus("valid_pat0", 4'd2, 4'd3, 1'b1);
    applyStimulus("valid_pat1", 4'd4, 4'd5, 1'b0);
    applyStimulus("valid_pat2", 4'd6, 4'd7, 1'b1);
    applyStimulus("valid_pat3", 4'd8, 4'd9, 1'b1);
    applyStimulus("valid_pat4", 4'd10, 4'd11, 1'b0);
    for (int k = 0; k < LAT; k++) applyStimulus("valid_drain", 4'd0, 4'd0, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus("pre_reset_sweep", 4'(i + 5), 4'(14 - i), 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midstream_reset", 8'h00, 1'b0);
    #4;
    rst_n = 1'b1;
    resetModel();
    for (int k = 0; k < LAT + 2; k++) applyStimulus("post_reset", 4'd11, 4'(k + 7), 1'b1);

    for (int k = 0; k < 60; k++)
      applyStimulus("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
